// File: rtl/led_matrix_scan_pwm.sv
// Dot-matrix LED driver: per-pixel brightness frame buffer scanned one row at a time
// with slot-based PWM, a range-checked pixel write port and a row-per-clock clear sweep.
module led_matrix_scan_pwm #(
    parameter int N_ROW     = 8,
    parameter int N_COL     = 8,
    parameter int BRIGHT_W  = 3,
    parameter int SCAN_DIV  = 4,
    parameter int DIM_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic                     clean,
    input  logic                     wr_en,
    input  logic [$clog2(N_ROW)-1:0] wr_row,
    input  logic [$clog2(N_COL)-1:0] wr_col,
    input  logic [BRIGHT_W+2:0]      wr_data,
    output logic                     wr_ack,
    output logic                     wr_err,
    output logic [$clog2(N_ROW)-1:0] row_d,
    output logic [$clog2(N_COL)-1:0] col_d,
    output logic                     clr_busy,
    output logic [$clog2(N_ROW)-1:0] scan_row,
    output logic                     frame_sync,
    output logic [N_ROW-1:0]         output_row,
    output logic [N_COL-1:0]         output_col_r,
    output logic [N_COL-1:0]         output_col_g
);
    localparam int RW  = $clog2(N_ROW);
    localparam int CW  = $clog2(N_COL);
    localparam int PXW = BRIGHT_W + 3;
    localparam int MAX = (1 << BRIGHT_W) - 1;
    localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DW-1:0]       DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [BRIGHT_W-1:0] SLOT_LAST = BRIGHT_W'(MAX);
    localparam logic [RW-1:0]       ROW_LAST  = RW'(N_ROW - 1);
    localparam logic [RW:0]         ROW_LIM   = (RW+1)'(N_ROW);
    localparam logic [CW:0]         COL_LIM   = (CW+1)'(N_COL);

    localparam logic [1:0] MODE_BLANK  = 2'b01;
    localparam logic [1:0] MODE_INVERT = 2'b10;
    localparam logic [1:0] MODE_LAMP   = 2'b11;

    logic [DW-1:0]       presc;
    logic [BRIGHT_W-1:0] slot;
    logic                presc_wrap;
    logic                slot_wrap;
    logic                row_wrap;

    logic [PXW-1:0]      fb [N_ROW][N_COL];
    logic [RW-1:0]       clr_row;
    logic                wr_take;
    logic                in_range;

    logic [N_ROW-1:0]    row_p0;
    logic [N_COL-1:0]    col_r_p0;
    logic [N_COL-1:0]    col_g_p0;
    logic [1:0]          px_drive;

    // Returns {green, red} drive for one pixel in PWM slot s (s is never 0 here).
    function automatic logic [1:0] pixel_drive(input logic [PXW-1:0] px,
                                               input logic [BRIGHT_W-1:0] s,
                                               input logic inv);
        logic [BRIGHT_W-1:0] eff;
        logic [1:0]          color;
        eff   = px[PXW-1] ? px[BRIGHT_W-1:0] : BRIGHT_W'(DIM_LEVEL);
        color = px[PXW-1] ? px[PXW-2 -: 2] : 2'b01;
        if (inv)
            eff = SLOT_LAST - eff;
        return (s <= eff) ? color : 2'b00;
    endfunction

    assign presc_wrap = (presc == DIV_LAST);
    assign slot_wrap  = presc_wrap && (slot == SLOT_LAST);
    assign row_wrap   = slot_wrap && (scan_row == ROW_LAST);

    // Slot counter is exactly BRIGHT_W bits wide, so it wraps MAX -> 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            slot       <= '0;
            scan_row   <= '0;
            frame_sync <= 1'b0;
        end else begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap)
                slot <= slot + 1'b1;
            if (slot_wrap)
                scan_row <= row_wrap ? '0 : scan_row + 1'b1;
            frame_sync <= row_wrap;
        end
    end

    assign wr_take  = wr_en && !clr_busy && !clean;
    assign in_range = ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_col} < COL_LIM);

    // A restart (clean while busy) only rewinds the sweep; it zeroes nothing that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_ROW; r++)
                for (int c = 0; c < N_COL; c++)
                    fb[r][c] <= '0;
            clr_busy <= 1'b0;
            clr_row  <= '0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            row_d    <= '0;
            col_d    <= '0;
        end else begin
            wr_ack <= wr_take && in_range;
            wr_err <= wr_take && !in_range;
            if (wr_take && in_range) begin
                fb[wr_row][wr_col] <= wr_data;
                row_d              <= wr_row;
                col_d              <= wr_col;
            end
            if (clean) begin
                clr_busy <= 1'b1;
                clr_row  <= '0;
            end else if (clr_busy) begin
                for (int c = 0; c < N_COL; c++)
                    fb[clr_row][c] <= '0;
                clr_row <= clr_row + 1'b1;
                if (clr_row == ROW_LAST)
                    clr_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        row_p0   = '1;
        col_r_p0 = '0;
        col_g_p0 = '0;
        px_drive = '0;
        if (mode == MODE_LAMP) begin
            row_p0   = '0;
            col_r_p0 = '1;
            col_g_p0 = '1;
        end else if (mode != MODE_BLANK && slot != '0) begin
            row_p0[scan_row] = 1'b0;
            for (int c = 0; c < N_COL; c++) begin
                px_drive    = pixel_drive(fb[scan_row][c], slot, mode == MODE_INVERT);
                col_r_p0[c] = px_drive[0];
                col_g_p0[c] = px_drive[1];
            end
        end
    end

    // Drive registers: one clock behind counter and buffer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_row   <= '1;
            output_col_r <= '0;
            output_col_g <= '0;
        end else begin
            output_row   <= row_p0;
            output_col_r <= col_r_p0;
            output_col_g <= col_g_p0;
        end
    end

endmodule
